// File: rtl/sha_nonce_feeder.sv
// rtl/sha_nonce_feeder.sv - nonce scanner that feeds SHA-256 second message blocks
// Walks nonce_start..nonce_end (with wrap) and strobes one padded block per issue.
module sha_nonce_feeder #(
  parameter int unsigned ISSUE_GAP  = 0,
  parameter int unsigned NONCE_STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic [95:0]  tail_in,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  output logic         en,
  output logic [511:0] M,
  output logic [31:0]  nonce,
  output logic         busy,
  output logic         done,
  output logic [31:0]  issued_count
);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, GAP, FIN} state_t;

  localparam logic [31:0] STEP     = NONCE_STEP[31:0];
  localparam logic [31:0] GAP_LAST = (ISSUE_GAP == 0) ? 32'd0 : ISSUE_GAP - 1;

  state_t      state;
  state_t      state_next;
  logic [95:0] tail_q;
  logic [31:0] start_q;
  logic [31:0] end_q;
  logic [31:0] nonce_cur;
  logic [31:0] gap_cnt;
  logic        accept;
  logic        issue;
  logic        last_issue;

  always_comb begin
    accept     = start && !stop;
    issue      = (state == ISSUE) && !stop;
    // Distance to the end is taken mod 2^32 so a wrapping range ends correctly.
    last_issue = (end_q - nonce_cur) < STEP;
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = LOAD;
      LOAD:    state_next = stop ? IDLE : ISSUE;
      ISSUE: begin
        if (stop)                state_next = IDLE;
        else if (last_issue)     state_next = FIN;
        else if (ISSUE_GAP > 0)  state_next = GAP;
        else                     state_next = ISSUE;
      end
      GAP: begin
        if (stop)                      state_next = IDLE;
        else if (gap_cnt == GAP_LAST)  state_next = ISSUE;
        else                           state_next = GAP;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tail_q       <= '0;
      start_q      <= '0;
      end_q        <= '0;
      nonce_cur    <= '0;
      gap_cnt      <= '0;
      en           <= 1'b0;
      M            <= '0;
      nonce        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      issued_count <= '0;
    end else begin
      state <= state_next;
      en    <= issue;
      done  <= (state == FIN);
      // Outputs lag the state by one cycle, so busy covers the final en cycle.
      busy  <= (state_next != IDLE);
      if (state == IDLE && accept) begin
        tail_q       <= tail_in;
        start_q      <= nonce_start;
        end_q        <= nonce_end;
        issued_count <= '0;
      end
      if (state == LOAD) nonce_cur <= start_q;
      if (issue) begin
        nonce        <= nonce_cur;
        M            <= {tail_q, nonce_cur, 32'h80000000, 320'h0, 64'h0000000000000280};
        issued_count <= issued_count + 32'd1;
        nonce_cur    <= nonce_cur + STEP;
        gap_cnt      <= '0;
      end
      if (state == GAP) gap_cnt <= gap_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_sha_nonce_feeder.sv
// tb/tb_sha_nonce_feeder.sv - scoreboard bench for sha_nonce_feeder
// dut0 uses default parameters, dut1 uses ISSUE_GAP=2 / NONCE_STEP=3.
module tb_sha_nonce_feeder;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic [95:0]  tail_in;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;

  logic         en0, busy0, done0;
  logic [511:0] m0;
  logic [31:0]  nonce0, cnt0;
  logic         en1, busy1, done1;
  logic [511:0] m1;
  logic [31:0]  nonce1, cnt1;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  sha_nonce_feeder dut0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .tail_in(tail_in),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .en(en0), .M(m0),
    .nonce(nonce0), .busy(busy0), .done(done0), .issued_count(cnt0)
  );

  sha_nonce_feeder #(.ISSUE_GAP(2), .NONCE_STEP(3)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .tail_in(tail_in),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .en(en1), .M(m1),
    .nonce(nonce1), .busy(busy1), .done(done1), .issued_count(cnt1)
  );

  function automatic logic [511:0] exp_m(input logic [95:0] t, input logic [31:0] n);
    return {t, n, 32'h80000000, 320'h0, 64'h0000000000000280};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Drives a one-cycle start; returns in the cycle after the accepting edge.
  task automatic begin_scan(input logic [95:0] t, input logic [31:0] s, input logic [31:0] e);
    tail_in     = t;
    nonce_start = s;
    nonce_end   = e;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (en0 !== 1'b0) begin bad++; $display("FAIL reset_en got=%0h want=0", en0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h want=0", busy0); end
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL reset_done got=%0h want=0", done0); end
    total++; if (nonce0 !== 32'h0) begin bad++; $display("FAIL reset_nonce got=%0h want=0", nonce0); end
    total++; if (cnt0 !== 32'h0) begin bad++; $display("FAIL reset_count got=%0h want=0", cnt0); end
    total++; if (m0 !== 512'h0) begin bad++; $display("FAIL reset_m got=%0h want=0", m0); end
  endtask

  task automatic test_sequence(input string name, input logic [95:0] t,
                               input logic [31:0] s, input logic [31:0] e);
    int n_exp, n_en, n_done, last_t;
    logic [31:0] want;
    do_reset();
    n_exp = int'(e - s) + 1;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(s + i[31:0]);
    n_en = 0; n_done = 0; last_t = -10;
    begin_scan(t, s, e);
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got=%0h want=1", name, busy0); end
    for (int c = 0; c < 20; c++) begin
      if (en0 === 1'b1) begin
        if (n_en == 0) begin
          total++; if (c != 2) begin bad++; $display("FAIL %s latency got=%0d want=2", name, c); end
        end else begin
          total++; if (c != last_t + 1) begin bad++; $display("FAIL %s spacing got=%0d want=%0d", name, c, last_t + 1); end
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL %s extra_en got=%0h want=none", name, nonce0);
        end else begin
          want = exp_q.pop_front();
          if (nonce0 !== want) begin bad++; $display("FAIL %s nonce got=%0h want=%0h", name, nonce0, want); end
          total++;
          if (m0 !== exp_m(t, want)) begin bad++; $display("FAIL %s m got=%0h want=%0h", name, m0, exp_m(t, want)); end
        end
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL %s busy_en got=%0h want=1", name, busy0); end
        n_en++; last_t = c;
      end
      if (done0 === 1'b1) begin
        total++; if (c != last_t + 1) begin bad++; $display("FAIL %s done_time got=%0d want=%0d", name, c, last_t + 1); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL %s busy_done got=%0h want=0", name, busy0); end
        n_done++;
      end
      step();
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL %s missing_en got=%0d want=0", name, exp_q.size()); end
    total++; if (n_done != 1) begin bad++; $display("FAIL %s done_count got=%0d want=1", name, n_done); end
    total++; if (cnt0 !== n_exp[31:0]) begin bad++; $display("FAIL %s issued_count got=%0d want=%0d", name, cnt0, n_exp); end
  endtask

  task automatic test_stop();
    int n_en, n_done;
    logic [31:0] want;
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    n_en = 0; n_done = 0;
    begin_scan(96'h1, 32'h0, 32'hFF);
    for (int c = 0; c < 20; c++) begin
      if (en0 === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL stop extra_en got=%0h want=none", nonce0);
        end else begin
          want = exp_q.pop_front();
          if (nonce0 !== want) begin bad++; $display("FAIL stop nonce got=%0h want=%0h", nonce0, want); end
        end
        n_en++;
      end
      if (done0 === 1'b1) n_done++;
      if (n_en == 2 && stop == 1'b0 && c < 5) begin
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL stop busy got=%0h want=0", busy0); end
        total++; if (en0 !== 1'b0) begin bad++; $display("FAIL stop en got=%0h want=0", en0); end
        if (en0 === 1'b1) n_en++;
      end else begin
        step();
      end
    end
    total++; if (n_en != 2) begin bad++; $display("FAIL stop en_count got=%0d want=2", n_en); end
    total++; if (n_done != 0) begin bad++; $display("FAIL stop done_count got=%0d want=0", n_done); end
    total++; if (cnt0 !== 32'd2) begin bad++; $display("FAIL stop issued_count got=%0d want=2", cnt0); end
  endtask

  task automatic test_gap_step();
    int n_en, n_done, last_t;
    logic [31:0] want;
    do_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back(3 * i[31:0]);
    n_en = 0; n_done = 0; last_t = -10;
    begin_scan(96'hABCDEF, 32'h0, 32'h7);
    for (int c = 0; c < 25; c++) begin
      if (en1 === 1'b1) begin
        if (n_en > 0) begin
          total++; if (c != last_t + 3) begin bad++; $display("FAIL gap spacing got=%0d want=%0d", c, last_t + 3); end
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL gap extra_en got=%0h want=none", nonce1);
        end else begin
          want = exp_q.pop_front();
          if (nonce1 !== want) begin bad++; $display("FAIL gap nonce got=%0h want=%0h", nonce1, want); end
        end
        n_en++; last_t = c;
      end
      if (done1 === 1'b1) n_done++;
      // Re-pulse start mid-scan with a different range; it must have no effect.
      start       = (c == 3);
      nonce_start = (c == 3) ? 32'h100 : 32'h0;
      step();
    end
    start = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL gap missing_en got=%0d want=0", exp_q.size()); end
    total++; if (n_done != 1) begin bad++; $display("FAIL gap done_count got=%0d want=1", n_done); end
    total++; if (cnt1 !== 32'd3) begin bad++; $display("FAIL gap issued_count got=%0d want=3", cnt1); end
  endtask

  task automatic test_reset_mid();
    int n_en, late_en;
    do_reset();
    n_en = 0; late_en = 0;
    begin_scan(96'h55, 32'h20, 32'hFF);
    for (int c = 0; c < 10 && n_en < 3; c++) begin
      if (en0 === 1'b1) n_en++;
      if (n_en < 3) step();
    end
    total++; if (n_en != 3) begin bad++; $display("FAIL rstmid pre_en got=%0d want=3", n_en); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if ({en0, busy0, done0} !== 3'b000) begin bad++; $display("FAIL rstmid flags got=%0b want=000", {en0, busy0, done0}); end
    total++; if (nonce0 !== 32'h0 || cnt0 !== 32'h0) begin bad++; $display("FAIL rstmid regs got=%0h/%0h want=0/0", nonce0, cnt0); end
    total++; if (m0 !== 512'h0) begin bad++; $display("FAIL rstmid m got=%0h want=0", m0); end
    for (int c = 0; c < 10; c++) begin
      if (en0 === 1'b1) late_en++;
      step();
    end
    total++; if (late_en != 0) begin bad++; $display("FAIL rstmid late_en got=%0d want=0", late_en); end
  endtask

  task automatic test_start_stop_idle();
    int active;
    do_reset();
    active = 0;
    tail_in = 96'h7; nonce_start = 32'h0; nonce_end = 32'h3;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (en0 === 1'b1 || busy0 === 1'b1 || done0 === 1'b1) active++;
      step();
    end
    total++; if (active != 0) begin bad++; $display("FAIL start_stop active got=%0d want=0", active); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    tail_in = '0; nonce_start = '0; nonce_end = '0;
    test_reset();
    test_sequence("t1", 96'h45F4992E74749054747B1B18, 32'h43F740C0, 32'h43F740C0);
    test_sequence("run4", 96'h123456789ABCDEF012345678, 32'h10, 32'h13);
    test_sequence("wrap", 96'hCAFE, 32'hFFFFFFFE, 32'h00000001);
    test_stop();
    test_gap_step();
    test_reset_mid();
    test_start_stop_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha_nonce_feeder.md
SHA_NONCE_FEEDER -- requirements
Module: sha_nonce_feeder

Interface
REQ-001 Parameter ISSUE_GAP, default 0: idle cycles inserted between consecutive issues (0 = one issue per cycle).
REQ-002 Parameter NONCE_STEP, default 1: nonce increment per issue, range 1..2^31.
REQ-003 The block SHALL use one clock, clk, and a synchronous, active-high reset, reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  request a scan, sampled only in IDLE.
REQ-007 stop  input  1  abort the scan in progress.
REQ-008 tail_in  input  96  header tail {merkle_tail, time, bits}, latched on start.
REQ-009 nonce_start  input  32  first nonce, latched on start.
REQ-010 nonce_end  input  32  last nonce, latched on start.
REQ-011 en  output  1  one-cycle strobe into sha_block; M is valid when en=1.
REQ-012 M  output  512  second SHA-256 message block of the 80-byte header.
REQ-013 nonce  output  32  nonce carried in M on the current issue.
REQ-014 busy  output  1  scan in progress.
REQ-015 done  output  1  one-cycle pulse after the final issue of a scan that is not aborted.
REQ-016 issued_count  output  32  en strobes since the last accepted start.

Function
REQ-017 M SHALL be {tail_latched[95:0], nonce[31:0], 32'h80000000, 320'h0, 64'h0000000000000280}, with M[511:416]=tail and M[415:384]=nonce.
REQ-018 All outputs SHALL be registered; M and nonce hold their last values when en=0.
REQ-019 The FSM SHALL have the states IDLE, LOAD, ISSUE, GAP and FIN.
REQ-020 IDLE: busy=0; start=1 and stop=0 -> latch tail_in, nonce_start, nonce_end; clear issued_count; go to LOAD.
REQ-021 LOAD: busy=1; set nonce_cur=nonce_start; go to ISSUE.
REQ-022 ISSUE: drive en=1 with nonce=nonce_cur; increment issued_count.
REQ-023 ISSUE, last issue when (nonce_end - nonce_cur) mod 2^32 < NONCE_STEP: go to FIN.
REQ-024 ISSUE, otherwise: nonce_cur += NONCE_STEP mod 2^32 (wraps FFFFFFFF->0); go to GAP if ISSUE_GAP>0, else stay in ISSUE.
REQ-025 GAP: en=0; after exactly ISSUE_GAP cycles in GAP, go to ISSUE.
REQ-026 FIN: done=1, busy=0, en=0 for one cycle; go to IDLE.
REQ-027 Latency: start sampled at edge k -> first en=1 in the cycle after edge k+2.
REQ-028 Throughput: consecutive en strobes SHALL be separated by exactly ISSUE_GAP cycles of en=0.
REQ-029 busy SHALL be 1 from the cycle after start is accepted through the last en cycle inclusive.
REQ-030 stop=1 in LOAD, ISSUE or GAP SHALL return the FSM to IDLE at the next edge.
REQ-031 On that stop no further en is issued, done is not pulsed, and issued_count is held.
REQ-032 stop has priority over a scheduled issue in the same cycle.
REQ-033 start while busy or in FIN SHALL be ignored.
REQ-034 start and stop together in IDLE: remain in IDLE.
REQ-035 nonce_start==nonce_end SHALL give exactly one issue.
REQ-036 nonce_end < nonce_start SHALL scan through the wrap.

Reset
REQ-037 reset=1 at any edge, including mid-scan, SHALL force IDLE and set en, busy, done, nonce, issued_count and M to 0.
REQ-038 The first start is accepted no earlier than the first edge with reset=0.

Verification
REQ-039 Reset mid-scan -> next cycle all outputs 0; no en until a new start.
REQ-040 tail_in=96'h45F4992E74749054747B1B18, nonce_start=nonce_end=32'h43F740C0, ISSUE_GAP=0.
  Response: one en with M=512'h45F4992E74749054747B1B1843F740C0800000000...0280 (matches sha_block T1_M2); done next cycle; issued_count=1.
REQ-041 nonce_start=32'h10, nonce_end=32'h13, ISSUE_GAP=0.
  Response: en high 4 consecutive cycles with nonce 10,11,12,13; then done; issued_count=4.
REQ-042 nonce_start=32'hFFFFFFFE, nonce_end=32'h00000001.
  Response: nonce sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; then done.
REQ-043 Range 0..FF, stop asserted in the cycle after the 2nd en.
  Response: no 3rd en; busy=0 next cycle; done never 1; issued_count=2.
REQ-044 ISSUE_GAP=2, NONCE_STEP=3, range 0..7, start re-pulsed while busy.
  Response: nonces 0, 3, 6, each separated by 2 idle cycles; re-pulsed start ignored; single done.
